// File: rtl/sublvds_tx_pattern_gen.sv
// Single-lane SubLVDS transmit word generator: builds H-blank/SAV/pixel/EAV symbol frames
// and gears each 12-bit symbol pair into three 8-bit words, earliest wire bit in px_data[0].
module sublvds_tx_pattern_gen #(
  parameter int          ACTIVE_PIX   = 1920,
  parameter int          H_BLANK      = 280,
  parameter int          V_ACTIVE     = 1080,
  parameter int          V_BLANK      = 45,
  parameter logic [11:0] BLANK_VAL    = 12'h040,
  parameter logic        RX_SWAP_MASK = 1'b0
) (
  input  logic        px_clk,
  input  logic        tx_reset,
  input  logic        tx_enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] fixed_val,
  output logic [7:0]  px_data,
  output logic        tx_frame_start,
  output logic        tx_busy,
  output logic [15:0] tx_frame_cnt
);

  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int LW      = $clog2(V_TOTAL + 1);
  localparam int SEG_MAX = (ACTIVE_PIX > H_BLANK) ? ACTIVE_PIX : H_BLANK;
  localparam int CW      = $clog2(SEG_MAX + 1);

  typedef enum logic [2:0] {IDLE, HBLANK, SAV, ACTIVE, EAV} state_t;

  state_t        state;
  logic [1:0]    phase;
  logic [CW-1:0] seg_cnt;
  logic [LW-1:0] line_cnt;
  logic [1:0]    pat_q;
  logic [11:0]   fixed_q;
  logic [15:0]   pair_q;
  logic [23:0]   pair_now;
  logic [11:0]   col0;
  logic [11:0]   line12;
  logic          valid_line;
  logic          last_line;
  logic          seg_last;
  logic          frame_end;
  logic          start_now;

  function automatic logic [11:0] clamp(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v == 12'h000) r = 12'h001;
    else if (v == 12'hFFF) r = 12'hFFE;
    return r;
  endfunction

  function automatic logic [11:0] pattern_pix(input logic [11:0] col, input logic [11:0] line,
                                              input logic [1:0] sel, input logic [11:0] fixed);
    logic [11:0] r;
    case (sel)
      2'd0:    r = col;
      2'd1:    r = col + line;
      2'd2:    r = fixed;
      default: r = col[0] ? 12'hAAA : 12'h555;
    endcase
    return r;
  endfunction

  // Bytes are held MSB-first as they leave the symbol; the wire wants the earliest bit in bit 0.
  function automatic logic [7:0] wire_order(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  always_comb begin
    valid_line = (line_cnt < LW'(V_ACTIVE));
    last_line  = (line_cnt == LW'(V_TOTAL - 1));
    col0       = 12'(seg_cnt);
    line12     = 12'(line_cnt);
    case (state)
      HBLANK:   seg_last = (seg_cnt == CW'(H_BLANK - 2));
      ACTIVE:   seg_last = (seg_cnt == CW'(ACTIVE_PIX - 2));
      SAV, EAV: seg_last = (seg_cnt == CW'(2));
      default:  seg_last = 1'b1;
    endcase
    frame_end = (state == EAV) && seg_last && last_line;
    start_now = tx_enable && ((state == IDLE) || frame_end);

    pair_now = {BLANK_VAL, BLANK_VAL};
    case (state)
      SAV: pair_now = (seg_cnt == '0) ? {12'hFFF, 12'h000}
                                      : {12'h000, valid_line ? 12'h800 : 12'hAB0};
      EAV: pair_now = (seg_cnt == '0) ? {12'hFFF, 12'h000}
                                      : {12'h000, valid_line ? 12'h9D0 : 12'hB60};
      ACTIVE: begin
        if (valid_line)
          pair_now = {clamp(pattern_pix(col0, line12, pat_q, fixed_q)),
                      clamp(pattern_pix(col0 + 12'd1, line12, pat_q, fixed_q))};
        else
          pair_now = {clamp(BLANK_VAL), clamp(BLANK_VAL)};
      end
      default: pair_now = {BLANK_VAL, BLANK_VAL};
    endcase
  end

  // The FSM only moves on phase-0 loads; phases 1 and 2 drain the held pair.
  always_ff @(posedge px_clk) begin
    if (tx_reset) begin
      state          <= IDLE;
      phase          <= 2'd0;
      seg_cnt        <= '0;
      line_cnt       <= '0;
      pat_q          <= 2'd0;
      fixed_q        <= 12'h000;
      pair_q         <= 16'h0000;
      px_data        <= 8'h00;
      tx_frame_start <= 1'b0;
      tx_busy        <= 1'b0;
      tx_frame_cnt   <= 16'h0000;
    end else begin
      tx_frame_start <= 1'b0;
      phase          <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
      case (phase)
        2'd0: begin
          px_data <= wire_order(pair_now[23:16]) ^ {8{RX_SWAP_MASK}};
          pair_q  <= pair_now[15:0];
          if (frame_end) tx_frame_cnt <= tx_frame_cnt + 16'd1;
          if (start_now) begin
            state          <= HBLANK;
            seg_cnt        <= '0;
            line_cnt       <= '0;
            pat_q          <= pattern_sel;
            fixed_q        <= fixed_val;
            tx_frame_start <= 1'b1;
            tx_busy        <= 1'b1;
          end else if (state != IDLE) begin
            if (!seg_last) begin
              seg_cnt <= seg_cnt + CW'(2);
            end else begin
              seg_cnt <= '0;
              case (state)
                HBLANK: state <= SAV;
                SAV:    state <= ACTIVE;
                ACTIVE: state <= EAV;
                default: begin
                  if (last_line) begin
                    state    <= IDLE;
                    line_cnt <= '0;
                    tx_busy  <= 1'b0;
                  end else begin
                    state    <= HBLANK;
                    line_cnt <= line_cnt + LW'(1);
                  end
                end
              endcase
            end
          end
        end
        2'd1:    px_data <= wire_order(pair_q[15:8]) ^ {8{RX_SWAP_MASK}};
        default: px_data <= wire_order(pair_q[7:0]) ^ {8{RX_SWAP_MASK}};
      endcase
    end
  end

endmodule

// File: tb/tb_sublvds_tx_pattern_gen.sv
// Bench for sublvds_tx_pattern_gen: a queue-based frame model predicts every output word,
// with directed steps for the idle pattern, SAV/pixel/EAV words, frame count, reset and lane inversion.
module tb_sublvds_tx_pattern_gen;

  localparam int          ACTIVE_PIX = 4;
  localparam int          H_BLANK    = 2;
  localparam int          V_ACTIVE   = 2;
  localparam int          V_BLANK    = 1;
  localparam logic [11:0] BLANK_VAL  = 12'h040;
  localparam int          LINE_SYMS  = H_BLANK + 8 + ACTIVE_PIX;
  localparam int          FRAME_SYMS = (V_ACTIVE + V_BLANK) * LINE_SYMS;
  localparam logic [7:0]  LINE0_WORDS [18] = '{8'hFF, 8'h0F, 8'h00, 8'h00, 8'h10, 8'h00,
                                               8'h00, 8'h08, 8'h80, 8'h00, 8'h04, 8'hC0,
                                               8'hFF, 8'h0F, 8'h00, 8'h00, 8'h90, 8'h0B};

  logic        px_clk = 1'b0;
  logic        tx_reset;
  logic        tx_enable;
  logic [1:0]  pattern_sel;
  logic [11:0] fixed_val;
  logic [7:0]  px_data, px_data_inv;
  logic        tx_frame_start, tx_frame_start_inv;
  logic        tx_busy, tx_busy_inv;
  logic [15:0] tx_frame_cnt, tx_frame_cnt_inv;

  int errors = 0;
  int checks = 0;

  logic [11:0] sym_q[$];
  logic [11:0] frame_syms[$];
  logic [7:0]  cap_q[$];
  logic [7:0]  cap_inv_q[$];
  bit          cap_on = 1'b0;
  int          m_phase = 0;
  logic [23:0] m_pair = '0;
  logic [7:0]  exp_px = '0;
  logic [7:0]  exp_px_inv = '0;
  logic        exp_start = 1'b0;
  logic        exp_busy = 1'b0;
  logic [15:0] exp_cnt = '0;

  sublvds_tx_pattern_gen #(
    .ACTIVE_PIX(ACTIVE_PIX), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE), .V_BLANK(V_BLANK),
    .BLANK_VAL(BLANK_VAL), .RX_SWAP_MASK(1'b0)
  ) dut (
    .px_clk(px_clk), .tx_reset(tx_reset), .tx_enable(tx_enable), .pattern_sel(pattern_sel),
    .fixed_val(fixed_val), .px_data(px_data), .tx_frame_start(tx_frame_start),
    .tx_busy(tx_busy), .tx_frame_cnt(tx_frame_cnt)
  );

  sublvds_tx_pattern_gen #(
    .ACTIVE_PIX(ACTIVE_PIX), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE), .V_BLANK(V_BLANK),
    .BLANK_VAL(BLANK_VAL), .RX_SWAP_MASK(1'b1)
  ) dut_inv (
    .px_clk(px_clk), .tx_reset(tx_reset), .tx_enable(tx_enable), .pattern_sel(pattern_sel),
    .fixed_val(fixed_val), .px_data(px_data_inv), .tx_frame_start(tx_frame_start_inv),
    .tx_busy(tx_busy_inv), .tx_frame_cnt(tx_frame_cnt_inv)
  );

  always #5 px_clk = ~px_clk;

  function automatic logic [11:0] ref_pixel(input int col, input int line,
                                            input logic [1:0] sel, input logic [11:0] fixed);
    logic [11:0] v;
    case (sel)
      2'd0:    v = 12'(col % 4096);
      2'd1:    v = 12'((col + line) % 4096);
      2'd2:    v = fixed;
      default: v = (col % 2 == 1) ? 12'hAAA : 12'h555;
    endcase
    if (v == 12'h000) v = 12'h001;
    else if (v == 12'hFFF) v = 12'hFFE;
    return v;
  endfunction

  // Whole-frame symbol list written straight from the line layout rules.
  function automatic void build_frame(input logic [1:0] sel, input logic [11:0] fixed);
    frame_syms.delete();
    for (int line = 0; line < V_ACTIVE + V_BLANK; line++) begin
      bit valid;
      valid = (line < V_ACTIVE);
      for (int k = 0; k < H_BLANK; k++) frame_syms.push_back(BLANK_VAL);
      frame_syms.push_back(12'hFFF); frame_syms.push_back(12'h000); frame_syms.push_back(12'h000);
      frame_syms.push_back(valid ? 12'h800 : 12'hAB0);
      for (int col = 0; col < ACTIVE_PIX; col++)
        frame_syms.push_back(valid ? ref_pixel(col, line, sel, fixed) : BLANK_VAL);
      frame_syms.push_back(12'hFFF); frame_syms.push_back(12'h000); frame_syms.push_back(12'h000);
      frame_syms.push_back(valid ? 12'h9D0 : 12'hB60);
    end
  endfunction

  function automatic void start_frame();
    build_frame(pattern_sel, fixed_val);
    foreach (frame_syms[k]) sym_q.push_back(frame_syms[k]);
    exp_start = 1'b1;
    exp_busy  = 1'b1;
  endfunction

  function automatic void model_edge();
    logic [11:0] a, b;
    if (tx_reset) begin
      sym_q.delete();
      m_phase    = 0;
      exp_px     = 8'h00;
      exp_px_inv = 8'h00;
      exp_start  = 1'b0;
      exp_busy   = 1'b0;
      exp_cnt    = 16'h0000;
    end else begin
      exp_start = 1'b0;
      if (m_phase == 0) begin
        if (sym_q.size() == 0) begin
          a = BLANK_VAL;
          b = BLANK_VAL;
          if (tx_enable) start_frame();
        end else begin
          a = sym_q.pop_front();
          b = sym_q.pop_front();
          if (sym_q.size() == 0) begin
            exp_cnt = exp_cnt + 16'd1;
            if (tx_enable) start_frame();
            else exp_busy = 1'b0;
          end
        end
        m_pair = {a, b};
      end
      for (int i = 0; i < 8; i++) exp_px[i] = m_pair[23 - (8 * m_phase + i)];
      exp_px_inv = ~exp_px;
      m_phase = (m_phase + 1) % 3;
    end
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    chk("px_data", px_data, exp_px);
    chk("px_data_inv", px_data_inv, exp_px_inv);
    chk("frame_start", tx_frame_start, exp_start);
    chk("frame_start_inv", tx_frame_start_inv, exp_start);
    chk("busy", tx_busy, exp_busy);
    chk("busy_inv", tx_busy_inv, exp_busy);
    chk("frame_cnt", tx_frame_cnt, exp_cnt);
    chk("frame_cnt_inv", tx_frame_cnt_inv, exp_cnt);
  endtask

  task automatic applyStimulus(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge px_clk);
      model_edge();
      #1;
      checkOutput();
      if (cap_on) begin
        cap_q.push_back(px_data);
        cap_inv_q.push_back(px_data_inv);
      end
    end
  endtask

  initial begin
    int n;
    int idx;
    int mism;
    logic [23:0] bits;
    logic [11:0] rec[$];

    tx_reset = 1'b1; tx_enable = 1'b0; pattern_sel = 2'd0; fixed_val = 12'h000;
    applyStimulus(3);
    chk("reset_px", px_data, 8'h00);
    chk("reset_cnt", tx_frame_cnt, 16'h0000);

    // Idle with enable low: the BLANK_VAL pair repeats as 20h,00h,02h.
    tx_reset = 1'b0;
    applyStimulus(1); chk("idle_w0", px_data, 8'h20);
    applyStimulus(1); chk("idle_w1", px_data, 8'h00);
    applyStimulus(1); chk("idle_w2", px_data, 8'h02);
    applyStimulus(9);
    chk("idle_busy", tx_busy, 1'b0);

    // First frame with the column ramp; line 0 words from SAV through EAV.
    tx_enable = 1'b1; pattern_sel = 2'd0;
    cap_q.delete(); cap_inv_q.delete(); cap_on = 1'b1;
    applyStimulus(30);
    cap_on = 1'b0;
    idx = -1;
    for (int i = 0; i + 1 < cap_q.size(); i++)
      if (idx < 0 && cap_q[i] == 8'hFF && cap_q[i+1] == 8'h0F) idx = i;
    chk("sav_found", 16'(idx >= 0 && idx + 18 <= cap_q.size()), 16'd1);
    if (idx >= 0 && idx + 18 <= cap_q.size())
      for (int k = 0; k < 18; k++) chk("line0_word", cap_q[idx + k], LINE0_WORDS[k]);

    // Enable held high: a second frame starts right after the first completes.
    n = 0;
    do begin applyStimulus(1); n++; end while (tx_frame_start !== 1'b1 && n < 200);
    chk("second_start", tx_frame_start, 1'b1);
    chk("cnt_after_frame1", tx_frame_cnt, 16'd1);

    // Mid-frame pattern change and enable drop take effect only at the boundary.
    applyStimulus(20);
    pattern_sel = 2'd3;
    tx_enable = 1'b0;
    n = 0;
    do begin applyStimulus(1); n++; end while (tx_busy !== 1'b0 && n < 200);
    chk("busy_dropped", tx_busy, 1'b0);
    chk("cnt_after_frame2", tx_frame_cnt, 16'd2);
    applyStimulus(9);
    chk("idle_again_busy", tx_busy, 1'b0);

    // Reset in the middle of line 1 pixels aborts the frame.
    tx_enable = 1'b1; pattern_sel = 2'd1;
    n = 0;
    do begin applyStimulus(1); n++; end while (sym_q.size() != FRAME_SYMS - 22 && n < 300);
    chk("reached_active", 16'(sym_q.size()), 16'(FRAME_SYMS - 22));
    tx_reset = 1'b1;
    applyStimulus(1);
    chk("abort_px", px_data, 8'h00);
    chk("abort_px_inv", px_data_inv, 8'h00);
    chk("abort_busy", tx_busy, 1'b0);
    chk("abort_cnt", tx_frame_cnt, 16'd0);

    // Restart with fixed FFFh: clamped pixels, inverted lane recovered by loopback.
    pattern_sel = 2'd2; fixed_val = 12'hFFF; tx_reset = 1'b0;
    applyStimulus(1); chk("restart_start", tx_frame_start, 1'b1);
    applyStimulus(1); chk("restart_start_low", tx_frame_start, 1'b0);
    applyStimulus(1);
    cap_q.delete(); cap_inv_q.delete(); cap_on = 1'b1;
    applyStimulus(FRAME_SYMS * 3 / 2);
    cap_on = 1'b0;
    rec.delete();
    for (int g = 0; g < FRAME_SYMS / 2; g++) begin
      for (int j = 0; j < 24; j++) bits[23 - j] = ~cap_inv_q[g * 3 + j / 8][j % 8];
      rec.push_back(bits[23:12]);
      rec.push_back(bits[11:0]);
    end
    build_frame(2'd2, 12'hFFF);
    mism = 0;
    for (int k = 0; k < FRAME_SYMS; k++) if (rec[k] !== frame_syms[k]) mism++;
    chk("loopback_mismatches", 16'(mism), 16'd0);
    chk("loopback_pix0", rec[H_BLANK + 4], 12'hFFE);

    // Randomized frames, enables and resets against the model.
    for (int r = 0; r < 8; r++) begin
      pattern_sel = 2'($urandom_range(0, 3));
      fixed_val   = 12'($urandom);
      tx_enable   = ($urandom_range(0, 3) != 0);
      if (r == 0) begin pattern_sel = 2'd2; fixed_val = 12'h000; tx_enable = 1'b1; end
      if (r > 0 && $urandom_range(0, 4) == 0) begin
        tx_reset = 1'b1;
        applyStimulus(int'($urandom_range(1, 3)));
        tx_reset = 1'b0;
      end
      applyStimulus(int'($urandom_range(20, 150)));
    end

    tx_enable = 1'b0;
    n = 0;
    do begin applyStimulus(1); n++; end while (tx_busy !== 1'b0 && n < 300);
    chk("final_idle_busy", tx_busy, 1'b0);
    applyStimulus(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
